// File: rtl/line_loader.sv
// Line loader: buffers NLINES input lines, kicks a downstream controller, accepts
// write-backs while it runs, then drains the buffer. Optional parity check: LINE_PARITY_EN.
module line_loader #(
    parameter int WIDTH  = 25,
    parameter int NLINES = 5,
    localparam int IW    = (NLINES > 1) ? $clog2(NLINES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             start,
    input  logic             done,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_line,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_line,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef LINE_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a line moves on any rising edge where valid and ready are both 1;
    // valid never waits on ready, and a held transfer keeps its data stable.

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] KICK  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [IW-1:0] LAST = IW'(NLINES - 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q [NLINES];
    logic [WIDTH-1:0] buf_d [NLINES];
    logic             wr_hit;
    logic             rd_hit;

`ifdef LINE_PARITY_EN
    logic par_err_q, par_err_d;
`endif

    assign wr_hit = wr_en && (int'(wr_idx) < NLINES);
    assign rd_hit = int'(rd_idx) < NLINES;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
`ifdef LINE_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d[cnt_q] = in_data;
`ifdef LINE_PARITY_EN
                    // Bad lines are still stored; the error is only flagged.
                    if ((^in_data) ^ in_par) begin
                        par_err_d = 1'b1;
                    end
`endif
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = KICK;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            KICK: begin
                state_d = RUN;
            end
            RUN: begin
                // A write in the same cycle as done still lands before DRAIN reads.
                if (wr_hit) begin
                    buf_d[wr_idx] = wr_line;
                end
                if (done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '{default: '0};
`ifdef LINE_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
`ifdef LINE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign in_ready  = (state_q == FILL) && !rst;
    assign start     = (state_q == KICK);
    assign busy      = (state_q != FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = (state_q == DRAIN) ? buf_q[cnt_q] : '0;
    assign rd_line   = rd_hit ? buf_q[rd_idx] : '0;
    assign state_dbg = state_q;

`ifdef LINE_PARITY_EN
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_line_loader.sv
// Self-checking bench for line_loader: directed steps plus randomized rounds
// checked against an array/queue model of the line buffer.
module tb_line_loader;

  localparam int WIDTH  = 25;
  localparam int NLINES = 5;
  localparam int IW     = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             start;
  logic             done = 1'b0;
  logic [IW-1:0]    rd_idx = '0;
  logic [WIDTH-1:0] rd_line;
  logic             wr_en = 1'b0;
  logic [IW-1:0]    wr_idx = '0;
  logic [WIDTH-1:0] wr_line = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [1:0]       state_dbg;
`ifdef LINE_PARITY_EN
  logic             in_par = 1'b0;
  logic             par_err;
`endif

  line_loader #(.WIDTH(WIDTH), .NLINES(NLINES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .done(done),
    .rd_idx(rd_idx), .rd_line(rd_line),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_line(wr_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef LINE_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .busy(busy), .state_dbg(state_dbg)
  );

  // reference model: buffer contents and the queue of lines expected out
  logic [WIDTH-1:0] exp_buf [NLINES];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fill_data [NLINES];
  int bad_par_idx = -1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NLINES; i++) exp_buf[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: fill NLINES lines with up to max_stall idle cycles before each;
  // idle cycles carry junk write-backs and done, which FILL must ignore
  task automatic fill_lines(input int max_stall);
    int stalls;
    for (int i = 0; i < NLINES; i++) begin
      stalls = $urandom_range(0, max_stall);
      repeat (stalls) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        wr_en    = 1'($urandom_range(0, 1));
        wr_idx   = IW'($urandom_range(0, 7));
        wr_line  = WIDTH'($urandom);
        done     = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("fill_stall_in_ready", in_ready, 1);
        check("fill_stall_busy", busy, 0);
        check("fill_stall_start", start, 0);
        step();
      end
      wr_en    = 1'b0;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = fill_data[i];
`ifdef LINE_PARITY_EN
      in_par = (^fill_data[i]) ^ (i == bad_par_idx);
`endif
      @(negedge clk);
      check("fill_in_ready", in_ready, 1);
      check("fill_no_out_valid", out_valid, 0);
      @(posedge clk);
      exp_buf[i] = fill_data[i];
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("kick_start", start, 1);
    check("kick_busy", busy, 1);
    check("kick_in_ready", in_ready, 0);
    step();
    @(negedge clk);
    check("run_start_low", start, 0);
    check("run_busy", busy, 1);
    step();
  endtask

  // combinational reads over every index, in-range and out-of-range
  task automatic check_reads();
    for (int i = 0; i < 8; i++) begin
      rd_idx = IW'(i);
      #1;
      check($sformatf("rd_line_idx%0d", i), rd_line, (i < NLINES) ? exp_buf[i] : '0);
    end
    step();
  endtask

  task automatic run_writes(input int n);
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] val;
    for (int k = 0; k < n; k++) begin
      idx     = IW'($urandom_range(0, 7));
      val     = WIDTH'($urandom);
      wr_en   = 1'b1;
      wr_idx  = idx;
      wr_line = val;
      @(negedge clk);
      check("run_busy_w", busy, 1);
      check("run_out_valid_w", out_valid, 0);
      @(posedge clk);
      if (int'(idx) < NLINES) exp_buf[idx] = val;
      #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic finish_run(input logic with_wr, input logic [IW-1:0] idx, input logic [WIDTH-1:0] val);
    done    = 1'b1;
    wr_en   = with_wr;
    wr_idx  = idx;
    wr_line = val;
    @(posedge clk);
    if (with_wr && int'(idx) < NLINES) exp_buf[idx] = val;
    #1;
    done  = 1'b0;
    wr_en = 1'b0;
  endtask

  // scoreboard drain: DRAIN must emit the model buffer in index order
  task automatic drain_lines(input int max_stall, input int first_stall);
    int stalls;
    logic [WIDTH-1:0] exp;
    exp_q.delete();
    for (int i = 0; i < NLINES; i++) exp_q.push_back(exp_buf[i]);
    for (int i = 0; i < NLINES; i++) begin
      exp    = exp_q[0];
      stalls = (i == 0 && first_stall > 0) ? first_stall : $urandom_range(0, max_stall);
      repeat (stalls) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = WIDTH'($urandom);
        done      = 1'($urandom_range(0, 1));
        wr_en     = 1'($urandom_range(0, 1));
        wr_idx    = IW'($urandom_range(0, 4));
        wr_line   = WIDTH'($urandom);
        @(negedge clk);
        check("drain_hold_valid", out_valid, 1);
        check("drain_hold_data", out_data, exp);
        check("drain_in_ready", in_ready, 0);
        step();
      end
      done      = 1'b0;
      wr_en     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_valid", out_valid, 1);
      check($sformatf("drain_data%0d", i), out_data, exp);
      @(posedge clk);
      void'(exp_q.pop_front());
      #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_drain_out_valid", out_valid, 0);
    check("post_drain_out_data", out_data, 0);
    check("post_drain_in_ready", in_ready, 1);
    check("post_drain_busy", busy, 0);
    check("post_drain_queue_empty", WIDTH'(exp_q.size()), 0);
    step();
  endtask

  task automatic random_fill_data();
    for (int i = 0; i < NLINES; i++) fill_data[i] = WIDTH'($urandom);
  endtask

  initial begin
    clear_model();

    // reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_line", rd_line, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // directed: lines 1..5 back to back, write-back with done, held drain
    for (int i = 0; i < NLINES; i++) fill_data[i] = WIDTH'(i + 1);
    fill_lines(0);
    rd_idx = 3'd2;
    #1;
    check("rd_idx2", rd_line, 25'h0000003);
    rd_idx = 3'd6;
    #1;
    check("rd_idx6", rd_line, 25'h0);
    check_reads();
    finish_run(1'b1, 3'd4, 25'h1ABCDEF);
    check("model_last_line", exp_buf[4], 25'h1ABCDEF);
    drain_lines(0, 3);

    // randomized rounds with stalls, out-of-range writes and back-pressure
    for (int r = 0; r < 4; r++) begin
      random_fill_data();
      fill_lines(2);
      run_writes($urandom_range(0, 4));
      check_reads();
      finish_run(1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)), WIDTH'($urandom));
      drain_lines(2, 0);
    end

    // reset in RUN after three writes
    random_fill_data();
    fill_lines(1);
    run_writes(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_start", start, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    for (int i = 0; i < NLINES; i++) begin
      rd_idx = IW'(i);
      #1;
      check($sformatf("midrst_buf%0d", i), rd_line, 0);
    end
    step();
    rst = 1'b0;
    clear_model();
    repeat (2) begin
      @(negedge clk);
      check("post_midrst_in_ready", in_ready, 1);
      check("post_midrst_start", start, 0);
      check("post_midrst_out_valid", out_valid, 0);
      step();
    end
    random_fill_data();
    fill_lines(1);
    check_reads();
    finish_run(1'b0, '0, '0);
    drain_lines(1, 0);

`ifdef LINE_PARITY_EN
    @(negedge clk);
    check("par_err_clean", par_err, 0);
    step();
    for (int i = 0; i < NLINES; i++) fill_data[i] = WIDTH'(i + 1);
    bad_par_idx = 2;
    fill_lines(0);
    check("par_err_set", par_err, 1);
    check_reads();
    finish_run(1'b0, '0, '0);
    @(negedge clk);
    check("par_err_drain", par_err, 1);
    step();
    drain_lines(0, 0);
    check("par_err_sticky", par_err, 1);
    bad_par_idx = -1;
    rst = 1'b1;
    #1;
    check("par_err_rst", par_err, 0);
    step();
    rst = 1'b0;
    clear_model();
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog: stop a hung run with a report
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
